// File: rtl/hf_ahb_pkg.sv
// Shared AHB-Lite encodings, default SoC map and default-slave state type
// for the hf_ahb interconnect.
package hf_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] GPIO_BASE   = 32'h5000_0000;
  localparam logic [31:0] MMA_BASE    = 32'h5100_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h5200_0000;
  localparam logic [31:0] REGION_MASK = 32'hFF00_0000;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  function automatic logic htrans_active(htrans_t t);
    return t[1];
  endfunction

endpackage

// File: rtl/hf_ahb_interconnect_if.sv
// AHB-Lite bus bundle between the master, the interconnect and N slaves.
interface hf_ahb_interconnect_if
  import hf_ahb_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  logic [W-1:0]            HADDR;
  htrans_t                 HTRANS;
  logic                    HWRITE;
  logic                    HREADY;
  logic                    HRESP;
  logic [W-1:0]            HRDATA;
  logic [NUM_SLAVES-1:0]   HSEL_S;
  logic [NUM_SLAVES-1:0]   HREADYOUT_S;
  logic [NUM_SLAVES-1:0]   HRESP_S;
  logic [NUM_SLAVES*W-1:0] HRDATA_S;

  modport slave (
    input  HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HREADY, HRESP, HRDATA, HSEL_S
  );

  modport master (
    output HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HREADY, HRESP, HRDATA, HSEL_S
  );
endinterface

// File: rtl/hf_ahb_default_slave.sv
// Default slave: OKAY for idle/busy, two-cycle ERROR for active transfers
// to unmapped addresses.
module hf_ahb_default_slave
  import hf_ahb_pkg::*;
(
  input  logic    HCLK,
  input  logic    HRESET,
  input  logic    hready,
  input  logic    sel,
  input  htrans_t htrans,
  output logic    hreadyout,
  output logic    hresp
);

  ds_state_t state, state_nxt;
  logic      start;

  assign start = hready & sel & htrans_active(htrans);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      DS_IDLE: if (start) state_nxt = DS_ERR1;
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp     = HRESP_ERROR;
        state_nxt = start ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/hf_ahb_interconnect.sv
// Single-master AHB-Lite interconnect: priority address decoder, data-phase
// response mux, built-in default slave and sticky bus-error capture.
module hf_ahb_interconnect
  import hf_ahb_pkg::*;
#(
  parameter int unsigned W                       = 32,
  parameter int unsigned NUM_SLAVES              = 4,
  parameter logic [NUM_SLAVES*W-1:0] SLAVE_BASE  = {PERIPH_BASE, MMA_BASE, GPIO_BASE, SRAM_BASE},
  parameter logic [NUM_SLAVES*W-1:0] SLAVE_MASK  = {NUM_SLAVES{REGION_MASK}}
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  hf_ahb_interconnect_if.slave bus,
  input  logic                 err_clr,
  output logic                 err_valid,
  output logic [W-1:0]         err_addr,
  output logic [5:0]           err_info,
  output logic                 err_irq
);

  logic [NUM_SLAVES-1:0] hit, sel, dsel;
  logic [3:0]            sel_idx, a_idx;
  logic                  sel_none, def_sel, found;
  logic [W-1:0]          a_addr;
  logic                  a_write;
  logic                  ds_ready, ds_resp;
  logic                  err_hit;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_hit
    assign hit[g] = (bus.HADDR & SLAVE_MASK[g*W +: W]) == SLAVE_BASE[g*W +: W];
  end

  // Lowest index wins on overlapping regions.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i] && !found) begin
        sel[i]  = 1'b1;
        sel_idx = 4'(i);
        found   = 1'b1;
      end
    end
  end

  assign sel_none   = ~found;
  assign bus.HSEL_S = sel;

  // Address-phase attributes follow the select register so the error log
  // describes the transfer whose data phase reports the error.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel    <= '0;
      def_sel <= 1'b1;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_idx   <= '0;
    end else if (bus.HREADY) begin
      dsel    <= sel;
      def_sel <= sel_none;
      a_addr  <= bus.HADDR;
      a_write <= bus.HWRITE;
      a_idx   <= sel_idx;
    end
  end

  hf_ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .hready    (bus.HREADY),
    .sel       (sel_none),
    .htrans    (bus.HTRANS),
    .hreadyout (ds_ready),
    .hresp     (ds_resp)
  );

  always_comb begin
    bus.HREADY = 1'b0;
    bus.HRESP  = HRESP_OKAY;
    bus.HRDATA = '0;
    if (def_sel) begin
      bus.HREADY = ds_ready;
      bus.HRESP  = ds_resp;
    end else begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (dsel[i]) begin
          bus.HREADY = bus.HREADYOUT_S[i];
          bus.HRESP  = bus.HRESP_S[i];
          bus.HRDATA = bus.HRDATA_S[i*W +: W];
        end
      end
    end
  end

  // First cycle of a two-cycle ERROR response; a clear in the same cycle
  // re-arms capture so the new error is kept.
  assign err_hit = bus.HRESP & ~bus.HREADY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_info  <= '0;
    end else if (err_hit && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= a_addr;
      err_info  <= {a_write, def_sel, a_idx};
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_info  <= '0;
    end
  end

  assign err_irq = err_valid;

endmodule

// File: tb/tb_hf_ahb_interconnect.sv
// Directed bench for hf_ahb_interconnect: default 4-slave map, a 2-slave
// overlapping map and a single-slave build.
module tb_hf_ahb_interconnect;
  import hf_ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  logic        err_clr, err_valid, err_irq;
  logic [31:0] err_addr;
  logic [5:0]  err_info;
  logic        o2_err_valid, o2_err_irq;
  logic [31:0] o2_err_addr;
  logic [5:0]  o2_err_info;
  logic        o1_err_valid, o1_err_irq;
  logic [31:0] o1_err_addr;
  logic [5:0]  o1_err_info;

  hf_ahb_interconnect_if #(.W(32), .NUM_SLAVES(4)) bus  ();
  hf_ahb_interconnect_if #(.W(32), .NUM_SLAVES(2)) bus2 ();
  hf_ahb_interconnect_if #(.W(32), .NUM_SLAVES(1)) bus1 ();

  hf_ahb_interconnect #(.W(32), .NUM_SLAVES(4)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave), .err_clr(err_clr),
    .err_valid(err_valid), .err_addr(err_addr), .err_info(err_info), .err_irq(err_irq)
  );

  hf_ahb_interconnect #(
    .W(32), .NUM_SLAVES(2),
    .SLAVE_BASE({32'h5000_0000, 32'h5000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hFF00_0000})
  ) u_ovl (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus2.slave), .err_clr(1'b0),
    .err_valid(o2_err_valid), .err_addr(o2_err_addr), .err_info(o2_err_info), .err_irq(o2_err_irq)
  );

  hf_ahb_interconnect #(
    .W(32), .NUM_SLAVES(1),
    .SLAVE_BASE(32'h0000_0000),
    .SLAVE_MASK(32'hFF00_0000)
  ) u_one (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus1.slave), .err_clr(1'b0),
    .err_valid(o1_err_valid), .err_addr(o1_err_addr), .err_info(o1_err_info), .err_irq(o1_err_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET  = 1'b0;
    err_clr = 1'b0;
    bus.HADDR = '0;  bus.HTRANS = HTRANS_IDLE;  bus.HWRITE = 1'b0;
    bus.HREADYOUT_S = '1;  bus.HRESP_S = '0;
    bus.HRDATA_S = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
    bus2.HADDR = '0; bus2.HTRANS = HTRANS_IDLE; bus2.HWRITE = 1'b0;
    bus2.HREADYOUT_S = '1; bus2.HRESP_S = '0; bus2.HRDATA_S = {32'hBBBB_0001, 32'hAAAA_0000};
    bus1.HADDR = '0; bus1.HTRANS = HTRANS_IDLE; bus1.HWRITE = 1'b0;
    bus1.HREADYOUT_S = '1; bus1.HRESP_S = '0; bus1.HRDATA_S = 32'h1111_0000;
    #1 HRESET = 1'b1;
    tick(); tick();
    #1;
    check("rst_hready",   64'(bus.HREADY), 64'd1);
    check("rst_hresp",    64'(bus.HRESP),  64'd0);
    check("rst_hrdata",   64'(bus.HRDATA), 64'd0);
    check("rst_err_valid",64'(err_valid),  64'd0);
    check("rst_err_addr", 64'(err_addr),   64'd0);
    check("rst_err_info", 64'(err_info),   64'd0);
    check("rst_err_irq",  64'(err_irq),    64'd0);
    HRESET = 1'b0;
    tick();

    // Mapped read with two wait states from slave1
    tick();
    bus.HADDR = 32'h5000_0004; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b0;
    #1 check("rd_hsel", 64'(bus.HSEL_S), 64'b0010);
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HREADYOUT_S = 4'b1101;
    #1 check("rd_wait1", 64'(bus.HREADY), 64'd0);
    tick();
    #1 check("rd_wait2", 64'(bus.HREADY), 64'd0);
    tick();
    bus.HREADYOUT_S = 4'b1111;
    #1;
    check("rd_ready", 64'(bus.HREADY), 64'd1);
    check("rd_data",  64'(bus.HRDATA), 64'hA5A5_0001);
    check("rd_resp",  64'(bus.HRESP),  64'd0);

    // Unmapped write
    tick();
    bus.HADDR = 32'h7000_0000; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    #1 check("um_hsel", 64'(bus.HSEL_S), 64'd0);
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    #1;
    check("um_cyc1", 64'({bus.HREADY, bus.HRESP}), 64'b01);
    check("um_cyc1_valid", 64'(err_valid), 64'd0);
    tick();
    #1;
    check("um_cyc2", 64'({bus.HREADY, bus.HRESP}), 64'b11);
    check("um_err_valid", 64'(err_valid), 64'd1);
    check("um_err_addr",  64'(err_addr),  64'h7000_0000);
    check("um_err_info",  64'(err_info),  64'b110000);
    check("um_err_irq",   64'(err_irq),   64'd1);
    tick();
    #1 check("um_after_okay", 64'({bus.HREADY, bus.HRESP}), 64'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 check("um_clr", 64'(err_valid), 64'd0);

    // Back-to-back SRAM then MMA
    tick();
    bus.HADDR = 32'h0000_0010; bus.HTRANS = HTRANS_NONSEQ;
    #1 check("b2b_hsel0", 64'(bus.HSEL_S), 64'b0001);
    tick();
    bus.HADDR = 32'h5100_0000;
    #1;
    check("b2b_hsel2",  64'(bus.HSEL_S), 64'b0100);
    check("b2b_rdy0",   64'(bus.HREADY), 64'd1);
    check("b2b_data0",  64'(bus.HRDATA), 64'h1111_0000);
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    #1;
    check("b2b_rdy2",   64'(bus.HREADY), 64'd1);
    check("b2b_data2",  64'(bus.HRDATA), 64'h2222_0002);

    // Sticky capture and clear-with-new-error
    tick();
    bus.HADDR = 32'h5100_0040; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b0;
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    bus.HREADYOUT_S = 4'b1011; bus.HRESP_S = 4'b0100;
    #1 check("st_s2_cyc1", 64'({bus.HREADY, bus.HRESP}), 64'b01);
    tick();
    bus.HREADYOUT_S = 4'b1111;
    bus.HADDR = 32'h6000_0000; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    #1;
    check("st_s2_cyc2",  64'({bus.HREADY, bus.HRESP}), 64'b11);
    check("st_s2_valid", 64'(err_valid), 64'd1);
    check("st_s2_addr",  64'(err_addr),  64'h5100_0040);
    check("st_s2_info",  64'(err_info),  64'b000010);
    tick();
    bus.HRESP_S = '0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    #1 check("st_um_cyc1", 64'({bus.HREADY, bus.HRESP}), 64'b01);
    tick();
    bus.HADDR = 32'h7000_0100; bus.HTRANS = HTRANS_NONSEQ;
    #1;
    check("st_um_cyc2",  64'({bus.HREADY, bus.HRESP}), 64'b11);
    check("st_hold_addr",64'(err_addr),  64'h5100_0040);
    check("st_hold_info",64'(err_info),  64'b000010);
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; err_clr = 1'b1;
    #1 check("st_3rd_cyc1", 64'({bus.HREADY, bus.HRESP}), 64'b01);
    tick();
    err_clr = 1'b0;
    #1;
    check("st_3rd_valid", 64'(err_valid), 64'd1);
    check("st_3rd_addr",  64'(err_addr),  64'h7000_0100);
    check("st_3rd_info",  64'(err_info),  64'b010000);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 check("st_cleared", 64'(err_valid), 64'd0);

    // Reset asserted during ERR1
    tick();
    bus.HADDR = 32'h7000_0000; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    tick();
    bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    #1 check("mr_err1", 64'({bus.HREADY, bus.HRESP}), 64'b01);
    HRESET = 1'b1;
    #1 check("mr_async", 64'({bus.HREADY, bus.HRESP}), 64'b10);
    tick();
    #1;
    check("mr_edge",  64'({bus.HREADY, bus.HRESP}), 64'b10);
    check("mr_valid", 64'(err_valid), 64'd0);
    HRESET = 1'b0;
    tick();
    tick();
    #1;
    check("mr_idle_okay", 64'({bus.HREADY, bus.HRESP}), 64'b10);
    check("mr_idle_valid", 64'(err_valid), 64'd0);

    // Overlapping two-slave map
    bus2.HADDR = 32'h5000_1234;
    #1 check("ovl_both", 64'(bus2.HSEL_S), 64'b01);
    bus2.HADDR = 32'h5800_0000;
    #1 check("ovl_s1",   64'(bus2.HSEL_S), 64'b10);
    bus2.HADDR = 32'h1000_0000;
    #1 check("ovl_none", 64'(bus2.HSEL_S), 64'b00);

    // Single-slave build
    tick();
    bus1.HADDR = 32'h0000_0100;
    #1 check("one_hit", 64'(bus1.HSEL_S), 64'd1);
    bus1.HADDR = 32'h7000_0000; bus1.HTRANS = HTRANS_NONSEQ; bus1.HWRITE = 1'b1;
    #1 check("one_um_hsel", 64'(bus1.HSEL_S), 64'd0);
    tick();
    bus1.HADDR = '0; bus1.HTRANS = HTRANS_IDLE; bus1.HWRITE = 1'b0;
    #1 check("one_cyc1", 64'({bus1.HREADY, bus1.HRESP}), 64'b01);
    tick();
    #1;
    check("one_cyc2",  64'({bus1.HREADY, bus1.HRESP}), 64'b11);
    check("one_valid", 64'(o1_err_valid), 64'd1);
    check("one_addr",  64'(o1_err_addr),  64'h7000_0000);
    check("one_info",  64'(o1_err_info),  64'b110000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
